// File: rtl/fetch_hazard_ctrl_if.sv
// Control bundle between the fetch/decode pipeline and its hazard controller.
// slave = controller side, master = pipeline side.
interface fetch_hazard_ctrl_if #(
   parameter int unsigned RA_W = 5
);
   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic            id_uses_rt;
   logic            id_jump;
   logic            ex_mem_read;
   logic [RA_W-1:0] ex_rt;
   logic            ex_branch;
   logic            ex_zero;
   logic            imem_ready;
   logic            halt_req;
   logic            pc_en;
   logic [1:0]      pc_sel;
   logic            if_id_en;
   logic            if_id_flush;
   logic            id_ex_flush;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch, ex_zero, imem_ready, halt_req,
      input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch, ex_zero, imem_ready, halt_req,
      output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush
   );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// PC / IF-ID / ID-EX sequencing controller: boot, redirects, load-use stall,
// instruction-memory wait, and a counted drain into halt.
module fetch_hazard_ctrl #(
   parameter int unsigned RA_W         = 5,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   fetch_hazard_ctrl_if.slave bus,
   output logic               halted,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;

   state_t          state, state_nx;
   logic [3:0]      drain_cnt, drain_cnt_nx;
   logic [RA_W-1:0] id_rs, id_rt, ex_rt;
   logic            taken, lu, stall_ev;
   logic            pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c;
   logic [1:0]      pc_sel_c;

   assign id_rs = bus.id_rs;
   assign id_rt = bus.id_rt;
   assign ex_rt = bus.ex_rt;

   assign taken = bus.ex_branch & bus.ex_zero;
   assign lu    = bus.ex_mem_read & (ex_rt != '0) & ~bus.id_jump &
                  ((ex_rt == id_rs) | (bus.id_uses_rt & (ex_rt == id_rt)));

   // Next state, drain countdown and prioritised control outputs
   always_comb begin
      state_nx      = state;
      drain_cnt_nx  = drain_cnt;
      pc_en_c       = 1'b0;
      pc_sel_c      = 2'b00;
      if_id_en_c    = 1'b0;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      case (state)
         BOOT: state_nx = RUN;
         RUN: begin
            if (taken) begin
               pc_en_c    = 1'b1;
               pc_sel_c   = 2'b10;
               if_id_en_c = 1'b1;
            end else if (bus.id_jump) begin
               pc_en_c       = 1'b1;
               pc_sel_c      = 2'b01;
               if_id_en_c    = 1'b1;
               id_ex_flush_c = 1'b0;
            end else if (lu) begin
               // hold PC and IF/ID, bubble into EX
               if_id_flush_c = 1'b0;
            end else if (!bus.imem_ready) begin
               if_id_en_c    = 1'b1;
               id_ex_flush_c = 1'b0;
            end else begin
               pc_en_c       = 1'b1;
               if_id_en_c    = 1'b1;
               if_id_flush_c = 1'b0;
               id_ex_flush_c = 1'b0;
            end
            if (bus.halt_req) begin
               state_nx     = DRAIN;
               drain_cnt_nx = 4'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            if_id_en_c    = 1'b1;
            id_ex_flush_c = 1'b0;
            if (drain_cnt == 4'd0) state_nx = HALT;
            else                   drain_cnt_nx = drain_cnt - 4'd1;
         end
         HALT: ;
         default: state_nx = BOOT;
      endcase
   end

   assign bus.pc_en       = pc_en_c;
   assign bus.pc_sel      = pc_sel_c;
   assign bus.if_id_en    = if_id_en_c;
   assign bus.if_id_flush = if_id_flush_c;
   assign bus.id_ex_flush = id_ex_flush_c;

   assign stall_ev = (state == RUN) & (~pc_en_c | if_id_flush_c | id_ex_flush_c);

   // State, drain counter and registered halt flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nx;
         drain_cnt <= drain_cnt_nx;
         halted    <= (state_nx == HALT);
      end
   end

   // Saturating stall/bubble counter, advances only in RUN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           stall_cnt <= '0;
      else if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_fetch_hazard_ctrl;

   localparam int unsigned RA_W  = 5;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DRAIN = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   fetch_hazard_ctrl_if #(.RA_W(RA_W)) bus ();

   fetch_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .halted    (halted),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string    name;
      bit [4:0] rs, rt;
      bit       uses_rt, jump, mem_read;
      bit [4:0] ex_rt;
      bit       branch, zero, ready, halt;
      bit [5:0] exp;   // {pc_en, pc_sel[1:0], if_id_en, if_id_flush, id_ex_flush}
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase tracked as plain counters/flags
   bit m_booting;
   int m_drain_left;
   bit m_halted;
   int m_cnt;

   function automatic vec_t mk(string nm, bit [4:0] rs, bit [4:0] rt, bit uses_rt,
                               bit jump, bit mem_read, bit [4:0] ex_rt, bit branch,
                               bit zero, bit ready, bit halt, bit [5:0] exp);
      vec_t v;
      v.name = nm; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump;
      v.mem_read = mem_read; v.ex_rt = ex_rt; v.branch = branch; v.zero = zero;
      v.ready = ready; v.halt = halt; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit [5:0] model_ctrl(vec_t v);
      bit taken, lu;
      if (m_booting || m_halted) return 6'b000011;
      if (m_drain_left > 0)      return 6'b000110;
      taken = v.branch && v.zero;
      lu = v.mem_read && v.ex_rt != 0 && !v.jump &&
           (v.ex_rt == v.rs || (v.uses_rt && v.ex_rt == v.rt));
      if (taken)    return 6'b110111;
      if (v.jump)   return 6'b101110;
      if (lu)       return 6'b000001;
      if (!v.ready) return 6'b000110;
      return 6'b100100;
   endfunction

   task automatic model_edge(vec_t v, bit [5:0] e);
      if (m_booting) m_booting = 1'b0;
      else if (m_halted) ;
      else if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1'b1;
      end else begin
         if (!e[5] || e[1] || e[0]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         if (v.halt) m_drain_left = DRAIN;
      end
   endtask

   function automatic bit [5:0] dut_ctrl();
      return {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush};
   endfunction

   task automatic drive(vec_t v);
      bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt;
      bus.id_jump = v.jump; bus.ex_mem_read = v.mem_read; bus.ex_rt = v.ex_rt;
      bus.ex_branch = v.branch; bus.ex_zero = v.zero; bus.imem_ready = v.ready;
      bus.halt_req = v.halt;
   endtask

   // one clock: drive, check at negedge, advance model at posedge
   task automatic cycle(vec_t v, bit use_tab);
      bit [5:0] e;
      drive(v);
      @(negedge clk);
      e = model_ctrl(v);
      chk({v.name, ".ctrl"}, 16'(dut_ctrl()), 16'(use_tab ? v.exp : e));
      chk({v.name, ".cnt"}, 16'(stall_cnt), 16'(m_cnt));
      chk({v.name, ".halted"}, 16'(halted), 16'(m_halted));
      @(posedge clk);
      model_edge(v, e);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(mk("z", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      #2;
      chk("reset.ctrl", 16'(dut_ctrl()), 16'(6'b000011));
      chk("reset.halted", 16'(halted), 16'd0);
      chk("reset.cnt", 16'(stall_cnt), 16'd0);
      m_booting = 1'b1; m_drain_left = 0; m_halted = 1'b0; m_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab[$];
      vec_t idle, w;
      int   halt_run;

      idle = mk("idle", 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);

      // boot then steady fetch
      do_reset();
      cycle(mk("boot", 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 6'b000011), 1);
      for (int i = 0; i < 4; i++) cycle(mk("run", 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 6'b100100), 1);
      chk("run.cnt0", 16'(stall_cnt), 16'd0);

      // single load-use stall, then rt=0 never stalls
      cycle(mk("lu1", 3, 0, 0, 0, 1, 3, 0, 0, 1, 0, 6'b000001), 1);
      chk("lu1.cnt", 16'(stall_cnt), 16'd1);
      cycle(mk("lu_x0", 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 6'b100100), 1);
      chk("lu_x0.cnt", 16'(stall_cnt), 16'd1);

      // 3 wait cycles with a load-use in the middle
      cycle(mk("w1", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110), 1);
      cycle(mk("w2lu", 4, 2, 0, 0, 1, 4, 0, 0, 0, 0, 6'b000001), 1);
      cycle(mk("w3", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110), 1);
      chk("wait3.cnt", 16'(stall_cnt), 16'd4);

      // directed priority table
      tab.push_back(mk("all_taken", 3, 3, 1, 1, 1, 3, 1, 1, 0, 0, 6'b110111));
      tab.push_back(mk("plain",     1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 6'b100100));
      tab.push_back(mk("lu_rt",     1, 5, 1, 0, 1, 5, 0, 0, 1, 0, 6'b000001));
      tab.push_back(mk("rt_unused", 1, 5, 0, 0, 1, 5, 0, 0, 1, 0, 6'b100100));
      tab.push_back(mk("lu_jump",   3, 0, 0, 1, 1, 3, 0, 0, 1, 0, 6'b101110));
      tab.push_back(mk("branch_nt", 1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 6'b100100));
      tab.push_back(mk("zero_only", 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 6'b100100));
      tab.push_back(mk("imem_wait", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110));
      tab.push_back(mk("lu_wait",   7, 2, 0, 0, 1, 7, 0, 0, 0, 0, 6'b000001));
      tab.push_back(mk("jump_wait", 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 6'b101110));
      tab.push_back(mk("tk_wait",   1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 6'b110111));
      tab.push_back(mk("ld_miss",   1, 2, 1, 0, 1, 6, 0, 0, 1, 0, 6'b100100));
      foreach (tab[i]) cycle(tab[i], 1);

      // halt: request cycle decodes normally, 4 drain cycles ignore a branch
      cycle(mk("halt_req", 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 6'b100100), 1);
      for (int i = 0; i < 4; i++) begin
         chk("drain.halted", 16'(halted), 16'd0);
         cycle(mk("drain", 3, 3, 1, 1, 1, 3, 1, 1, 1, 1, 6'b000110), 1);
      end
      chk("halt.halted", 16'(halted), 16'd1);
      for (int i = 0; i < 3; i++) cycle(mk("halt", 1, 2, 0, 0, 0, 0, 1, 1, 1, 0, 6'b000011), 1);
      chk("halt.held", 16'(halted), 16'd1);

      // reset from HALT returns to BOOT
      do_reset();
      cycle(mk("boot2", 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011), 1);

      // saturation
      for (int i = 0; i < 20; i++) cycle(mk("sat", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110), 1);
      chk("sat.cnt", 16'(stall_cnt), 16'(CMAX));

      // randomized traffic against the model
      do_reset();
      halt_run = 0;
      for (int i = 0; i < 600; i++) begin
         w = idle;
         w.name     = $sformatf("rnd%0d", i);
         w.rs       = 5'($urandom_range(0, 3));
         w.rt       = 5'($urandom_range(0, 3));
         w.ex_rt    = 5'($urandom_range(0, 3));
         w.uses_rt  = 1'($urandom_range(0, 1));
         w.mem_read = 1'($urandom_range(0, 1));
         w.branch   = ($urandom_range(0, 3) == 0);
         w.zero     = 1'($urandom_range(0, 1));
         w.jump     = ($urandom_range(0, 7) == 0);
         w.ready    = ($urandom_range(0, 4) != 0);
         w.halt     = ($urandom_range(0, 79) == 0);
         cycle(w, 0);
         if (m_halted) halt_run++;
         if (halt_run >= 3) begin
            halt_run = 0;
            do_reset();
         end else if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
